// File: rtl/vault_phase_sequencer.sv
// Master sequencer for the vault puzzle phases: enables one phase FSM at a time, clears it
// before use, collects its sticky result, counts failures and enforces an alarm lockout.
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | waiting for start (level); attempts_left holds remaining fails
// CLEAR    | one-cycle phase_clr pulse, timeout counter zeroed
// RUN      | active phase enabled, waiting for its done/fail or timeout
// ADVANCE  | one cycle between phases, current_phase already incremented
// OPEN     | vault open; leaves only on a rising edge of start
// PENALTY  | one cycle, charges a failed attempt
// LOCKOUT  | alarm raised for LOCKOUT_CYCLES, start ignored
module vault_phase_sequencer #(
    parameter int NUM_PHASES     = 3,
    parameter int MAX_ATTEMPTS   = 3,
    parameter int PHASE_TIMEOUT  = 5000,
    parameter int LOCKOUT_CYCLES = 10000
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    input  logic [NUM_PHASES-1:0] phase_done_i,
    input  logic [NUM_PHASES-1:0] phase_fail_i,
    output logic [NUM_PHASES-1:0] phase_en_o,
    output logic                  phase_clr_o,
    output logic [2:0]            current_phase_o,
    output logic [3:0]            attempts_left_o,
    output logic                  busy_o,
    output logic                  vault_open_o,
    output logic                  alarm_o
);

    localparam int TW = $clog2(PHASE_TIMEOUT) + 1;
    localparam int LW = $clog2(LOCKOUT_CYCLES) + 1;

    localparam logic [TW-1:0] TMO_LAST   = TW'(PHASE_TIMEOUT - 1);
    localparam logic [LW-1:0] LOCK_LAST  = LW'(LOCKOUT_CYCLES - 1);
    localparam logic [3:0]    ATT_MAX    = 4'(MAX_ATTEMPTS);
    localparam logic [2:0]    PHASE_LAST = 3'(NUM_PHASES - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_RUN     = 3'd2;
    localparam logic [2:0] S_ADVANCE = 3'd3;
    localparam logic [2:0] S_OPEN    = 3'd4;
    localparam logic [2:0] S_PENALTY = 3'd5;
    localparam logic [2:0] S_LOCKOUT = 3'd6;

    logic [2:0]            state_q, state_d;
    logic [2:0]            phase_q, phase_d;
    logic [3:0]            att_q, att_d;
    logic [TW-1:0]         tmo_q, tmo_d;
    logic [LW-1:0]         lock_q, lock_d;
    logic                  start_prev_q;

    logic [NUM_PHASES-1:0] phase_en_q, phase_en_d;
    logic                  phase_clr_q, phase_clr_d;
    logic                  busy_q, busy_d;
    logic                  open_q, open_d;
    logic                  alarm_q, alarm_d;

    logic                  sel_done;
    logic                  sel_fail;
    logic                  start_rise;
    logic [3:0]            att_dec;

    // Only the active phase's result bits matter; the rest are ignored.
    always_comb begin
        sel_done = 1'b0;
        sel_fail = 1'b0;
        for (int i = 0; i < NUM_PHASES; i++) begin
            if (phase_q == 3'(i)) begin
                sel_done = phase_done_i[i];
                sel_fail = phase_fail_i[i];
            end
        end
    end

    assign start_rise = start_i & ~start_prev_q;
    assign att_dec    = (att_q == 4'd0) ? 4'd0 : att_q - 4'd1;

    always_comb begin
        state_d = state_q;
        phase_d = phase_q;
        att_d   = att_q;
        tmo_d   = tmo_q;
        lock_d  = lock_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_CLEAR;
                    phase_d = 3'd0;
                end
            end

            S_CLEAR: begin
                tmo_d   = '0;
                state_d = S_RUN;
            end

            S_RUN: begin
                // A simultaneous done and fail is charged as a failure.
                if (sel_fail) begin
                    state_d = S_PENALTY;
                end else if (sel_done) begin
                    if (phase_q == PHASE_LAST) begin
                        state_d = S_OPEN;
                        att_d   = ATT_MAX;
                    end else begin
                        state_d = S_ADVANCE;
                        phase_d = phase_q + 3'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    state_d = S_PENALTY;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end

            S_ADVANCE: begin
                state_d = S_CLEAR;
            end

            S_PENALTY: begin
                att_d  = att_dec;
                lock_d = '0;
                if (att_dec == 4'd0) begin
                    state_d = S_LOCKOUT;
                end else begin
                    state_d = S_IDLE;
                    phase_d = 3'd0;
                end
            end

            S_OPEN: begin
                // Re-arming needs a fresh press so a held start cannot relock the vault.
                if (start_rise) begin
                    state_d = S_CLEAR;
                    phase_d = 3'd0;
                end
            end

            S_LOCKOUT: begin
                if (lock_q == LOCK_LAST) begin
                    state_d = S_IDLE;
                    att_d   = ATT_MAX;
                end else begin
                    lock_d = lock_q + LW'(1);
                end
            end

            default: begin
                state_d = S_IDLE;
                phase_d = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so the registered copies line up with state_q.
    always_comb begin
        phase_en_d = '0;
        if (state_d == S_RUN) begin
            for (int i = 0; i < NUM_PHASES; i++) begin
                phase_en_d[i] = (phase_d == 3'(i));
            end
        end
        phase_clr_d = (state_d == S_CLEAR);
        busy_d      = (state_d == S_CLEAR) || (state_d == S_RUN) ||
                      (state_d == S_ADVANCE) || (state_d == S_PENALTY);
        open_d      = (state_d == S_OPEN);
        alarm_d     = (state_d == S_LOCKOUT);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            phase_q      <= 3'd0;
            att_q        <= ATT_MAX;
            tmo_q        <= '0;
            lock_q       <= '0;
            start_prev_q <= 1'b0;
            phase_en_q   <= '0;
            phase_clr_q  <= 1'b0;
            busy_q       <= 1'b0;
            open_q       <= 1'b0;
            alarm_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            att_q        <= att_d;
            tmo_q        <= tmo_d;
            lock_q       <= lock_d;
            start_prev_q <= start_i;
            phase_en_q   <= phase_en_d;
            phase_clr_q  <= phase_clr_d;
            busy_q       <= busy_d;
            open_q       <= open_d;
            alarm_q      <= alarm_d;
        end
    end

    assign phase_en_o      = phase_en_q;
    assign phase_clr_o     = phase_clr_q;
    assign current_phase_o = phase_q;
    assign attempts_left_o = att_q;
    assign busy_o          = busy_q;
    assign vault_open_o    = open_q;
    assign alarm_o         = alarm_q;

endmodule

// File: doc/vault_phase_sequencer.md
Name: vault_phase_sequencer

Overview:
- Master controller that drives the vault's puzzle-phase FSMs and consumes their results.
- Each phase FSM latches its result after leaving IDLE and reports it as a sticky level:
  - phaseN_done = 1 on pass.
  - phaseN_fail = 1 on fail.
- The sequencer does the following:
  - Enables one phase at a time.
  - Clears each phase block before use.
  - Collects its result.
  - Counts failed attempts.
  - Raises the alarm and enforces a lockout after too many failures.
- Top-level vault logic uses vault_open and alarm.

Parameters:
- NUM_PHASES, 3, number of chained phase FSMs (2..8).
- MAX_ATTEMPTS, 3, failed attempts allowed before alarm/lockout (1..15).
- PHASE_TIMEOUT, 5000, cycles a phase may run without a result before it counts as a fail.
- LOCKOUT_CYCLES, 10000, cycles held in LOCKOUT before returning to IDLE.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  level; sampled in IDLE only, begins a new attempt at phase 0.
- phase_done  in  NUM_PHASES  bit i = sticky done level from phase i.
- phase_fail  in  NUM_PHASES  bit i = sticky fail level from phase i.
- phase_en  out  NUM_PHASES  one-hot enable of the active phase; all zero otherwise.
- phase_clr  out  1  one-cycle pulse that returns all phase FSMs to their IDLE state.
- current_phase  out  3  index of the active or last-active phase.
- attempts_left  out  4  remaining failures allowed.
- busy  out  1  high in any state other than IDLE, OPEN or LOCKOUT.
- vault_open  out  1  high while in OPEN.
- alarm  out  1  high while in LOCKOUT.

Behaviour:
- Reset values (asynchronous, reset low):
  - State = IDLE.
  - phase_en = 0, phase_clr = 0, current_phase = 0.
  - attempts_left = MAX_ATTEMPTS.
  - busy = 0, vault_open = 0, alarm = 0.
  - Timers = 0.
- All outputs are registered.
- States: IDLE, CLEAR, RUN, ADVANCE, OPEN, PENALTY, LOCKOUT.
- IDLE:
  - start = 1 -> CLEAR, with current_phase = 0.
- CLEAR (exactly 1 cycle):
  - phase_clr = 1, phase_en = 0.
  - Timeout counter = 0.
  - Next state RUN.
- RUN:
  - phase_en = one-hot(current_phase); timeout counter increments every cycle.
  - Only bit current_phase of phase_done/phase_fail is examined; all other bits are ignored.
  - done and fail both high in the same cycle: treated as fail.
  - fail -> PENALTY.
  - done, current_phase < NUM_PHASES-1 -> ADVANCE.
  - done, last phase -> OPEN.
  - Counter reaches PHASE_TIMEOUT-1 with no result -> PENALTY.
- ADVANCE (1 cycle):
  - current_phase increments, phase_en = 0.
  - Next state CLEAR, so the next phase starts clean.
- PENALTY (1 cycle):
  - attempts_left decrements, saturating at 0.
  - If the decremented value is 0 -> LOCKOUT; otherwise -> IDLE, with current_phase = 0.
- OPEN:
  - vault_open = 1; attempts_left reloads to MAX_ATTEMPTS.
  - Held until start deasserts and then reasserts (rising edge), which re-arms via CLEAR for a new unlock.
- LOCKOUT:
  - alarm = 1, phase_en = 0.
  - start is ignored.
  - Lockout counter runs LOCKOUT_CYCLES cycles, then:
    - state -> IDLE;
    - attempts_left reloads to MAX_ATTEMPTS;
    - alarm drops in the same cycle.
- start held high in IDLE after a PENALTY return starts a new attempt immediately (no edge requirement); only OPEN needs an edge.
- Reset asserted mid-operation: immediate return to reset values; the lockout is not preserved.
- Counter widths: $clog2 of the respective parameter + 1. No overflow possible, because each counter is compared before it increments.

Test Plan:
1. Pass with no failures:
   - Stimulus: NUM_PHASES=3; start=1; done on phases 0, 1, 2, each 4 cycles after phase_en.
   - Required: phase_clr pulses 3 times; phase_en goes 001 -> 010 -> 100; vault_open=1; attempts_left=3.
2. Single failure:
   - Stimulus: fail on phase 1.
   - Required: PENALTY, then IDLE; attempts_left=2; current_phase=0; phase_en=000; alarm=0.
3. Lockout and recovery:
   - Stimulus: 3 consecutive fails on phase 0, with LOCKOUT_CYCLES=20.
   - Required: alarm=1 for exactly 20 cycles; start ignored during lockout; then IDLE with attempts_left=3.
4. Phase timeout:
   - Stimulus: PHASE_TIMEOUT=16; no result from phase 0.
   - Required: PENALTY entered 16 cycles after RUN entry; attempts_left decrements.
5. Simultaneous and off-phase results:
   - Stimulus: done and fail both high on the active phase -> treated as fail.
   - Stimulus: phase_done[2]=1 while phase 0 is active -> ignored.
6. Asynchronous reset:
   - Stimulus: reset low mid-RUN and mid-LOCKOUT.
   - Required: outputs reach reset values without waiting for a clock edge; attempts_left=3.
